hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central pipeline controller for the 5-stage RISC-V core. It sits beside the F/D/E/M/W pipeline registers and drives four kinds of control:
- operand forwarding selects into the execute stage;
- load-use stalls;
- branch/jump flushes of the decode and execute registers;
- whole-pipeline freezes while data memory is not ready.

A wait FSM enforces a memory timeout watchdog. Two saturating counters record stall and flush activity.

Parameters:
REGISTER_ADDRESS_WIDTH, 5, width of register specifiers
TIMEOUT, 16, consecutive not-ready memory cycles before the error state (legal range ≥2)
PERF_WIDTH, 16, width of performance counters

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
Rs1D_i, Rs2D_i  in  RAW  source registers in decode
Rs1E_i, Rs2E_i  in  RAW  source registers in execute
RdE_i, RdM_i, RdW_i  in  RAW  destination registers in E/M/W
ResultSrcE_i  in  2  result select in E; 2'b01 means load
RegWriteM_i, RegWriteW_i  in  1  write-back enables in M/W
PCSrcE_i  in  1  taken branch or jump resolved in E
MemReqM_i  in  1  load/store active in M
DMemReady_i  in  1  data memory completes the M access this cycle
ForwardAE_o, ForwardBE_o  out  2  00 register file, 10 ALUResultM, 01 ResultW
StallF_o, StallD_o, StallE_o, StallM_o, StallW_o  out  1  hold the stage register
FlushD_o, FlushE_o  out  1  synchronous clear of the D and E registers
MemTimeout_o  out  1  sticky watchdog error
StallCycles_o  out  PERF_WIDTH  cycles with any stall asserted
FlushCount_o  out  PERF_WIDTH  branch/jump flush events

(RAW = REGISTER_ADDRESS_WIDTH.)

Behaviour:

Forwarding (combinational, active in every state):
- ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E.
- Else ForwardAE = 01 if RegWriteW & RdW≠0 & RdW==Rs1E.
- Else ForwardAE = 00.
- ForwardBE follows the same rules with Rs2E.
- M has priority over W. x0 is never forwarded.

FSM states RUN, WAIT, ERROR; a wait counter wcnt runs alongside.
- RUN:
  - freeze = MemReqM & ~DMemReady.
  - If freeze: next state WAIT, wcnt←1.
- WAIT:
  - freeze = ~DMemReady.
  - On DMemReady: freeze drops the same cycle; next state RUN, wcnt←0.
  - Otherwise: if wcnt==TIMEOUT-1, next state ERROR; else wcnt++.
  - Net effect: ERROR is entered at the edge that ends the TIMEOUT-th consecutive not-ready cycle.
- ERROR:
  - freeze=1 permanently and MemTimeout_o=1.
  - Left only by reset.

Freeze (combinational from state and inputs):
- All Stall*_o = 1 and FlushD/FlushE = 0.
- Load-use and branch logic are suppressed. The held PCSrcE_i re-evaluates after the freeze ends.

When not frozen:
- lwStall = (ResultSrcE==01) & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- StallF = StallD = lwStall & ~PCSrcE.
- FlushD = PCSrcE.
- FlushE = PCSrcE | lwStall.
- StallE, StallM, StallW = 0.
- If lwStall and PCSrcE occur together, PCSrcE wins: flush only, no stall.

Counters (registered, saturating at all-ones, never wrap):
- StallCycles increments on every cycle in which any Stall*_o=1, including ERROR.
- FlushCount increments on every non-frozen cycle with PCSrcE=1.

Reset (asynchronous, rst_ni low):
- State RUN, wcnt=0, counters 0, MemTimeout_o=0.
- While rst_ni=0, force FlushD_o=FlushE_o=1 and all Stall*_o=0.
- Reset asserted mid-WAIT or in ERROR returns to RUN immediately.

Latency: all stall, flush and forward outputs are combinational, with zero-cycle response. Counters and MemTimeout_o update one edge after the qualifying cycle.

Test Plan:
- EX→EX forwarding: RdM=5, RegWriteM=1, Rs1E=5, and RdW=5, RegWriteW=1 → ForwardAE=10. Drop RegWriteM → ForwardAE=01. With RdM=0 and RegWriteW=0 → ForwardAE=00 whatever Rs1E is.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=1, FlushE=1, FlushD=0 for one cycle; StallCycles goes 0→1. Same with RdE=0 → no stall.
- Branch flush: PCSrcE=1 → FlushD=FlushE=1, no stalls; FlushCount=1. PCSrcE=1 together with a load-use match → StallF=StallD=0, FlushE=1.
- Memory wait: MemReqM=1, DMemReady=0 for 3 cycles, then 1 → all Stall*_o=1 for exactly 3 cycles, 0 on the ready cycle; StallCycles=3; FSM back in RUN; no flushes during the freeze even with PCSrcE=1.
- Timeout: DMemReady held 0 with MemReqM=1 for TIMEOUT=16 cycles → MemTimeout_o=1 from cycle 17. DMemReady later =1 → freeze stays. Assert rst_ni=0 → MemTimeout_o=0, counters 0, FlushD=FlushE=1 at once.
- Saturation: PERF_WIDTH=4, 20 freeze cycles → StallCycles stays at 15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Central hazard controller for the 5-stage RISC-V pipeline.
//   - Forwarding selects for the two execute-stage operands (M over W, x0 never).
//   - Load-use stall of F/D with a bubble flushed into E.
//   - Branch/jump flush of the D and E registers.
//   - Whole-pipeline freeze while data memory is not ready, guarded by a
//     watchdog FSM (RUN/WAIT/ERROR) that latches a sticky timeout error.
//   - Saturating performance counters for stall cycles and flush events.
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   Rs1D_i, Rs2D_i                decode source registers
//   Rs1E_i, Rs2E_i                execute source registers
//   RdE_i, RdM_i, RdW_i           destination registers in E/M/W
//   ResultSrcE_i                  result select in E (2'b01 = load)
//   RegWriteM_i, RegWriteW_i      write-back enables in M/W
//   PCSrcE_i                      taken branch/jump resolved in E
//   MemReqM_i, DMemReady_i        M-stage memory request / completion
//   ForwardAE_o, ForwardBE_o      00 regfile, 10 ALUResultM, 01 ResultW
//   StallF_o..StallW_o            hold the stage register
//   FlushD_o, FlushE_o            synchronous clear of the D/E registers
//   MemTimeout_o                  sticky watchdog error
//   StallCycles_o, FlushCount_o   saturating activity counters
//   dbg_state_o                   FSM state (0 RUN, 1 WAIT, 2 ERROR)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int REGISTER_ADDRESS_WIDTH = 5,
   parameter int TIMEOUT                = 16,
   parameter int PERF_WIDTH             = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_ni,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1D_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2D_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs1E_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] Rs2E_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdE_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdM_i,
   input  logic [REGISTER_ADDRESS_WIDTH-1:0] RdW_i,
   input  logic [1:0]                        ResultSrcE_i,
   input  logic                              RegWriteM_i,
   input  logic                              RegWriteW_i,
   input  logic                              PCSrcE_i,
   input  logic                              MemReqM_i,
   input  logic                              DMemReady_i,
   output logic [1:0]                        ForwardAE_o,
   output logic [1:0]                        ForwardBE_o,
   output logic                              StallF_o,
   output logic                              StallD_o,
   output logic                              StallE_o,
   output logic                              StallM_o,
   output logic                              StallW_o,
   output logic                              FlushD_o,
   output logic                              FlushE_o,
   output logic                              MemTimeout_o,
   output logic [PERF_WIDTH-1:0]             StallCycles_o,
   output logic [PERF_WIDTH-1:0]             FlushCount_o,
   output logic [1:0]                        dbg_state_o
);

   localparam int WCW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [WCW-1:0]          wcnt_q, wcnt_d;
   logic [PERF_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
   logic [PERF_WIDTH-1:0]   flush_cnt_q, flush_cnt_d;
   logic                    freeze;
   logic                    lw_stall;
   logic                    any_stall;

   // Forwarding: M stage has priority over W, register x0 is never forwarded.
   always_comb begin
      ForwardAE_o = 2'b00;
      ForwardBE_o = 2'b00;
      if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs1E_i))
         ForwardAE_o = 2'b10;
      else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs1E_i))
         ForwardAE_o = 2'b01;
      if (RegWriteM_i && (RdM_i != '0) && (RdM_i == Rs2E_i))
         ForwardBE_o = 2'b10;
      else if (RegWriteW_i && (RdW_i != '0) && (RdW_i == Rs2E_i))
         ForwardBE_o = 2'b01;
   end

   // Watchdog FSM: next state and freeze. In WAIT the freeze follows ready
   // alone so the completing cycle is already unfrozen.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      freeze  = 1'b0;
      unique case (state_q)
         ST_RUN: begin
            freeze = MemReqM_i & ~DMemReady_i;
            if (freeze) begin
               state_d = ST_WAIT;
               wcnt_d  = WCW'(1);
            end
         end
         ST_WAIT: begin
            freeze = ~DMemReady_i;
            if (DMemReady_i) begin
               state_d = ST_RUN;
               wcnt_d  = '0;
            end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
               state_d = ST_ERROR;
            end else begin
               wcnt_d = wcnt_q + WCW'(1);
            end
         end
         ST_ERROR: begin
            freeze = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
            wcnt_d  = '0;
         end
      endcase
   end

   // Stall / flush outputs. Reset forces a flush and no stalls; a freeze
   // suppresses load-use and branch handling; a branch beats a load-use stall.
   always_comb begin
      lw_stall = (ResultSrcE_i == 2'b01) && (RdE_i != '0) &&
                 ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));
      StallF_o = 1'b0;
      StallD_o = 1'b0;
      StallE_o = 1'b0;
      StallM_o = 1'b0;
      StallW_o = 1'b0;
      FlushD_o = 1'b0;
      FlushE_o = 1'b0;
      if (!rst_ni) begin
         FlushD_o = 1'b1;
         FlushE_o = 1'b1;
      end else if (freeze) begin
         StallF_o = 1'b1;
         StallD_o = 1'b1;
         StallE_o = 1'b1;
         StallM_o = 1'b1;
         StallW_o = 1'b1;
      end else begin
         StallF_o = lw_stall & ~PCSrcE_i;
         StallD_o = lw_stall & ~PCSrcE_i;
         FlushD_o = PCSrcE_i;
         FlushE_o = PCSrcE_i | lw_stall;
      end
   end

   // Saturating activity counters.
   always_comb begin
      any_stall   = StallF_o | StallD_o | StallE_o | StallM_o | StallW_o;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (any_stall && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + PERF_WIDTH'(1);
      if (!freeze && PCSrcE_i && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + PERF_WIDTH'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_RUN;
         wcnt_q      <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign MemTimeout_o  = (state_q == ST_ERROR);
   assign StallCycles_o = stall_cnt_q;
   assign FlushCount_o  = flush_cnt_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Two instances share all inputs: the main
// one (PERF_WIDTH=16) and a narrow one (PERF_WIDTH=4) for counter saturation.
// Expected output vectors are queued when a step is driven and popped and
// compared at the falling edge; counters are compared against bench-side
// saturating models after each rising edge.
//
// Handshake note: there is no valid/ready interface here; inputs are driven
// 1 time unit after the rising edge and outputs sampled at the falling edge.
//
// Expected vector layout (14 bits):
//   [13:12] state  [11:10] ForwardAE  [9:8] ForwardBE
//   [7] StallF [6] StallD [5] StallE [4] StallM [3] StallW
//   [2] FlushD [1] FlushE [0] MemTimeout
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   localparam int W = 14;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
   logic [1:0] result_src_e;
   logic       reg_write_m, reg_write_w, pcsrc_e, mem_req_m, dmem_ready;

   logic [1:0]  fa, fb, fa2, fb2, st, st2;
   logic        sf, sd, se, sm, sw, fd, fe, to;
   logic        sf2, sd2, se2, sm2, sw2, fd2, fe2, to2;
   logic [15:0] stall_cnt, flush_cnt;
   logic [3:0]  stall_cnt2, flush_cnt2;

   hazard_ctrl #(.REGISTER_ADDRESS_WIDTH(5), .TIMEOUT(16), .PERF_WIDTH(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
      .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw), .ResultSrcE_i(result_src_e),
      .RegWriteM_i(reg_write_m), .RegWriteW_i(reg_write_w), .PCSrcE_i(pcsrc_e),
      .MemReqM_i(mem_req_m), .DMemReady_i(dmem_ready),
      .ForwardAE_o(fa), .ForwardBE_o(fb),
      .StallF_o(sf), .StallD_o(sd), .StallE_o(se), .StallM_o(sm), .StallW_o(sw),
      .FlushD_o(fd), .FlushE_o(fe), .MemTimeout_o(to),
      .StallCycles_o(stall_cnt), .FlushCount_o(flush_cnt), .dbg_state_o(st)
   );

   hazard_ctrl #(.REGISTER_ADDRESS_WIDTH(5), .TIMEOUT(16), .PERF_WIDTH(4)) dut_narrow (
      .clk_i(clk), .rst_ni(rst_n),
      .Rs1D_i(rs1d), .Rs2D_i(rs2d), .Rs1E_i(rs1e), .Rs2E_i(rs2e),
      .RdE_i(rde), .RdM_i(rdm), .RdW_i(rdw), .ResultSrcE_i(result_src_e),
      .RegWriteM_i(reg_write_m), .RegWriteW_i(reg_write_w), .PCSrcE_i(pcsrc_e),
      .MemReqM_i(mem_req_m), .DMemReady_i(dmem_ready),
      .ForwardAE_o(fa2), .ForwardBE_o(fb2),
      .StallF_o(sf2), .StallD_o(sd2), .StallE_o(se2), .StallM_o(sm2), .StallW_o(sw2),
      .FlushD_o(fd2), .FlushE_o(fe2), .MemTimeout_o(to2),
      .StallCycles_o(stall_cnt2), .FlushCount_o(flush_cnt2), .dbg_state_o(st2)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int           n_total = 0;
   int           n_bad   = 0;
   logic [15:0]  stall_m, flush_m;
   logic [3:0]   stall4_m, flush4_m;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ev(input logic [1:0] s, input logic [1:0] a,
                                       input logic [1:0] b, input logic stall_fd,
                                       input logic frz, input logic flush_d,
                                       input logic flush_e, input logic tmo);
      return {s, a, b, stall_fd | frz, stall_fd | frz, frz, frz, frz,
              flush_d, flush_e, tmo};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      rs1d = '0; rs2d = '0; rs1e = '0; rs2e = '0;
      rde = '0; rdm = '0; rdw = '0; result_src_e = 2'b00;
      reg_write_m = 1'b0; reg_write_w = 1'b0; pcsrc_e = 1'b0;
      mem_req_m = 1'b0; dmem_ready = 1'b1;
   endtask

   // One clock cycle with the current inputs: compare outputs at the falling
   // edge, then compare counters just after the next rising edge.
   task automatic cycle(input string tag, input logic [W-1:0] e);
      logic [W-1:0] exp_v;
      exp_q.push_back(e);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      chk({tag, "/out"}, 32'({st, fa, fb, sf, sd, se, sm, sw, fd, fe, to}), 32'(exp_v));
      chk({tag, "/out_n"}, 32'({st2, fa2, fb2, sf2, sd2, se2, sm2, sw2, fd2, fe2, to2}),
          32'(exp_v));
      if (|exp_v[7:3]) begin
         if (stall_m != 16'hFFFF) stall_m++;
         if (stall4_m != 4'hF) stall4_m++;
      end
      if (exp_v[2]) begin
         if (flush_m != 16'hFFFF) flush_m++;
         if (flush4_m != 4'hF) flush4_m++;
      end
      @(posedge clk);
      #1;
      chk({tag, "/stall_cnt"}, 32'(stall_cnt), 32'(stall_m));
      chk({tag, "/flush_cnt"}, 32'(flush_cnt), 32'(flush_m));
      chk({tag, "/stall_cnt_n"}, 32'(stall_cnt2), 32'(stall4_m));
      chk({tag, "/flush_cnt_n"}, 32'(flush_cnt2), 32'(flush4_m));
   endtask

   task automatic reset_models();
      stall_m = '0; flush_m = '0; stall4_m = '0; flush4_m = '0;
   endtask

   // Assert reset asynchronously and check the forced outputs immediately.
   task automatic apply_reset(input string tag);
      rst_n = 1'b0;
      #1;
      reset_models();
      chk({tag, "/flush_d"}, 32'(fd), 32'd1);
      chk({tag, "/flush_e"}, 32'(fe), 32'd1);
      chk({tag, "/stalls"}, 32'({sf, sd, se, sm, sw}), 32'd0);
      chk({tag, "/timeout"}, 32'(to), 32'd0);
      chk({tag, "/state"}, 32'(st), 32'd0);
      chk({tag, "/stall_cnt"}, 32'(stall_cnt), 32'd0);
      chk({tag, "/flush_cnt"}, 32'(flush_cnt), 32'd0);
      chk({tag, "/stall_cnt_n"}, 32'(stall_cnt2), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      clear_inputs();
      reset_models();
      @(posedge clk);
      #1;
      apply_reset("reset0");

      // Forwarding
      rdm = 5'd5; reg_write_m = 1'b1; rs1e = 5'd5; rdw = 5'd5; reg_write_w = 1'b1;
      cycle("fwd_m_over_w", ev(2'd0, 2'b10, 2'b00, 0, 0, 0, 0, 0));
      reg_write_m = 1'b0; rs2e = 5'd5;
      cycle("fwd_w", ev(2'd0, 2'b01, 2'b01, 0, 0, 0, 0, 0));
      rdm = 5'd0; reg_write_m = 1'b1; reg_write_w = 1'b0; rs1e = 5'd0; rs2e = 5'd0;
      cycle("fwd_x0", ev(2'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
      rs1e = 5'd9; rdm = 5'd3; rs2e = 5'd3; rdw = 5'd3; reg_write_w = 1'b1;
      cycle("fwd_b_m", ev(2'd0, 2'b00, 2'b10, 0, 0, 0, 0, 0));
      clear_inputs();

      // Load-use
      result_src_e = 2'b01; rde = 5'd7; rs2d = 5'd7;
      cycle("lw_rs2", ev(2'd0, 2'b00, 2'b00, 1, 0, 0, 1, 0));
      rs2d = 5'd0; rs1d = 5'd7;
      cycle("lw_rs1", ev(2'd0, 2'b00, 2'b00, 1, 0, 0, 1, 0));
      rde = 5'd0; rs1d = 5'd0;
      cycle("lw_x0", ev(2'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
      result_src_e = 2'b00; rde = 5'd7; rs1d = 5'd7;
      cycle("no_load", ev(2'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0));
      clear_inputs();

      // Branch flush, and branch beating a load-use stall
      pcsrc_e = 1'b1;
      cycle("branch", ev(2'd0, 2'b00, 2'b00, 0, 0, 1, 1, 0));
      result_src_e = 2'b01; rde = 5'd4; rs1d = 5'd4;
      cycle("branch_lw", ev(2'd0, 2'b00, 2'b00, 0, 0, 1, 1, 0));
      clear_inputs();

      // Memory wait of 3 cycles with a pending branch held during the freeze
      mem_req_m = 1'b1; dmem_ready = 1'b0; pcsrc_e = 1'b1;
      cycle("mw1", ev(2'd0, 2'b00, 2'b00, 0, 1, 0, 0, 0));
      cycle("mw2", ev(2'd1, 2'b00, 2'b00, 0, 1, 0, 0, 0));
      cycle("mw3", ev(2'd1, 2'b00, 2'b00, 0, 1, 0, 0, 0));
      dmem_ready = 1'b1;
      cycle("mw_ready", ev(2'd1, 2'b00, 2'b00, 0, 0, 1, 1, 0));
      clear_inputs();
      cycle("mw_run", ev(2'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0));

      // Timeout: 16 not-ready cycles, error from cycle 17
      mem_req_m = 1'b1; dmem_ready = 1'b0;
      cycle("to_c1", ev(2'd0, 2'b00, 2'b00, 0, 1, 0, 0, 0));
      for (int i = 2; i <= 16; i++)
         cycle($sformatf("to_c%0d", i), ev(2'd1, 2'b00, 2'b00, 0, 1, 0, 0, 0));
      cycle("to_c17", ev(2'd2, 2'b00, 2'b00, 0, 1, 0, 0, 1));
      dmem_ready = 1'b1; mem_req_m = 1'b0; pcsrc_e = 1'b1;
      cycle("to_sticky", ev(2'd2, 2'b00, 2'b00, 0, 1, 0, 0, 1));
      cycle("to_sticky2", ev(2'd2, 2'b00, 2'b00, 0, 1, 0, 0, 1));
      @(negedge clk);
      apply_reset("reset_err");
      clear_inputs();
      cycle("post_reset", ev(2'd0, 2'b00, 2'b00, 0, 0, 0, 0, 0));

      // Saturation: 20 freeze cycles
      mem_req_m = 1'b1; dmem_ready = 1'b0;
      for (int i = 1; i <= 20; i++)
         cycle($sformatf("sat_c%0d", i),
               ev((i == 1) ? 2'd0 : (i <= 16) ? 2'd1 : 2'd2, 2'b00, 2'b00, 0, 1, 0, 0,
                  (i >= 17) ? 1'b1 : 1'b0));
      chk("sat_narrow_final", 32'(stall_cnt2), 32'd15);
      chk("sat_wide_final", 32'(stall_cnt), 32'd20);

      // Reset while frozen in WAIT returns to RUN at once
      @(negedge clk);
      apply_reset("reset_final");
      clear_inputs();
      mem_req_m = 1'b1; dmem_ready = 1'b0;
      cycle("wait_again1", ev(2'd0, 2'b00, 2'b00, 0, 1, 0, 0, 0));
      cycle("wait_again2", ev(2'd1, 2'b00, 2'b00, 0, 1, 0, 0, 0));
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_mid_wait/state", 32'(st), 32'd0);
      chk("reset_mid_wait/stalls", 32'({sf, sd, se, sm, sw}), 32'd0);
      chk("reset_mid_wait/flush", 32'({fd, fe}), 32'd3);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      n_bad++;
      $display("FAIL timeout observed=running expected=finished");
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
